// File: rtl/score_packer.sv
// score_packer: serial-to-parallel packer feeding the argmax stage.
// Accepts N unsigned W-bit scores one per cycle (InValid/InReady), packs
// score k into Num[k*W +: W], then presents the frame with NumValid and
// holds it frozen until NumAck, after which it refills from slot 0.
// Latency: NumValid rises the cycle after the N-th accept.
// Backpressure: InReady is low while a frame is held and during reset.
// Optional feature macro: RUNNING_MAX_EN (adds MaxIndex/MaxValue, a running
// argmax over the frame; ties keep the lowest index).
// Ports:
//   clk, GlobalReset (async, active-high)
//   InValid/InData/InReady : score input handshake
//   Num/NumValid/NumAck    : packed frame output and consumer ack
//   Count                  : scores accepted in the current frame
//   MaxIndex/MaxValue      : running max (RUNNING_MAX_EN only)
module score_packer #(
  parameter int N    = 10,
  parameter int W    = 26,
  parameter int IDXW = 4
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              InValid,
  input  logic [W-1:0]      InData,
  output logic              InReady,
  output logic [N*W-1:0]    Num,
  output logic              NumValid,
  input  logic              NumAck,
  output logic [IDXW-1:0]   Count
`ifdef RUNNING_MAX_EN
  ,
  output logic [IDXW-1:0]   MaxIndex,
  output logic [W-1:0]      MaxValue
`endif
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  logic [0:0]      r_state;
  logic [IDXW-1:0] r_count;
  logic [N*W-1:0]  r_num;
  logic            w_accept;
  logic            w_last;

  // Ready is state-decoded; gated by reset so nothing is offered while the
  // block is held in reset.
  assign InReady  = (r_state == ST_FILL) && !GlobalReset;
  assign NumValid = (r_state == ST_HOLD);
  assign Num      = r_num;
  assign Count    = r_count;

  assign w_accept = InValid && (r_state == ST_FILL);
  assign w_last   = (r_count == LAST_IDX);

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state <= ST_FILL;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_count <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: begin
          // Data offered while holding is dropped; only the ack matters.
          if (NumAck) r_state <= ST_FILL;
        end
      endcase
    end
  end

  // Slots are overwritten in order on refill; no clear between frames.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_num <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_accept && (r_count == IDXW'(k))) r_num[k*W +: W] <= InData;
      end
    end
  end

`ifdef RUNNING_MAX_EN
  logic [IDXW-1:0] r_max_idx;
  logic [W-1:0]    r_max_val;
  logic            w_gt;

  // Strictly greater: equal scores keep the earlier (lower) index.
  assign w_gt     = (InData > r_max_val);
  assign MaxIndex = r_max_idx;
  assign MaxValue = r_max_val;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_max_idx <= '0;
      r_max_val <= '0;
    end else if (w_accept && ((r_count == '0) || w_gt)) begin
      r_max_idx <= r_count;
      r_max_val <= InData;
    end
  end
`endif

endmodule
